// File: rtl/bp_lce_req_arb.sv
// Two-input LCE request merger: a small FIFO per input, round-robin grant between them,
// and a registered output carrying the packet plus the index of the input it came from.
module bp_lce_req_arb #(
  parameter int width_p = 64,
  parameter int els_p   = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [1:0][width_p-1:0] req_i,
  input  logic [1:0]              req_v_i,
  output logic [1:0]              req_ready_o,
  output logic [width_p-1:0]      req_o,
  output logic                    req_src_o,
  output logic                    req_v_o,
  input  logic                    req_ready_i
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  // Handshake: on the input side a packet is accepted on any posedge where req_v_i[i] is high
  // (the sender only raises it while req_ready_o[i] is high); on the output side a packet
  // leaves on any posedge where req_v_o and req_ready_i are both high.

  logic [1:0]              nonempty;
  logic [1:0][width_p-1:0] head;
  logic                    load_en;
  logic                    grant_v;
  logic                    grant_idx;

  logic [width_p-1:0] req_q, req_d;
  logic               src_q, src_d;
  logic               v_q, v_d;
  logic               last_grant_q, last_grant_d;

  for (genvar i = 0; i < 2; i++) begin : g_fifo
    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0]   count_q, count_d;
    logic               enq;
    logic               deq;

    // Ready depends on the registered count only, so a dequeue frees space a cycle later.
    assign req_ready_o[i] = (count_q != cnt_w'(els_p));
    assign nonempty[i]    = (count_q != '0);
    assign head[i]        = mem_q[rd_ptr_q];
    assign enq            = req_v_i[i] & req_ready_o[i];
    assign deq            = grant_v & (grant_idx == 1'(i));

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) begin
        wr_ptr_d = (wr_ptr_q == ptr_w'(els_p - 1)) ? '0 : wr_ptr_q + ptr_w'(1);
      end
      if (deq) begin
        rd_ptr_d = (rd_ptr_q == ptr_w'(els_p - 1)) ? '0 : rd_ptr_q + ptr_w'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + cnt_w'(1);
        2'b01:   count_d = count_q - cnt_w'(1);
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (enq) begin
        mem_q[wr_ptr_q] <= req_i[i];
      end
    end
  end

  assign load_en = ~v_q | req_ready_i;
  assign grant_v = load_en & (|nonempty);

  // With both inputs waiting, the one not granted last time wins.
  always_comb begin
    if (&nonempty) begin
      grant_idx = ~last_grant_q;
    end else begin
      grant_idx = nonempty[1];
    end
  end

  always_comb begin
    req_d        = req_q;
    src_d        = src_q;
    v_d          = v_q;
    last_grant_d = last_grant_q;
    if (grant_v) begin
      req_d        = head[grant_idx];
      src_d        = grant_idx;
      v_d          = 1'b1;
      last_grant_d = grant_idx;
    end else if (load_en) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_q        <= '0;
      src_q        <= 1'b0;
      v_q          <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      req_q        <= req_d;
      src_q        <= src_d;
      v_q          <= v_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req_o     = req_q;
  assign req_src_o = src_q;
  assign req_v_o   = v_q;

endmodule
